// File: rtl/i2c_reg_bank_pkg.sv
// i2c_reg_bank_pkg: shared slave state codes, register map boundaries and map read helper
package i2c_reg_bank_pkg;
  localparam logic [4:0] ST_IDLE = 5'd0;
  localparam logic [4:0] OFFSET_ACK = 5'd6;
  localparam logic [7:0] RW_LAST = 8'h07;
  localparam logic [7:0] RO_FIRST = 8'h08;
  localparam logic [7:0] STATUS_LAST = 8'h0B;
  localparam logic [7:0] ID_OFFSET = 8'h0F;
  localparam logic [7:0] UNMAPPED_VALUE = 8'hFF;
  function automatic logic [7:0] map_read(input logic [7:0] ofs, input logic [63:0] cfg,
                                          input logic [31:0] status, input logic [7:0] id);
    return ofs <= RW_LAST ? cfg[{ofs[2:0], 3'b000} +: 8] :
           ofs <= STATUS_LAST ? status[{ofs[1:0], 3'b000} +: 8] :
           ofs < ID_OFFSET ? 8'h00 :
           ofs == ID_OFFSET ? id : UNMAPPED_VALUE;
  endfunction
endpackage

// File: rtl/i2c_reg_bank_if.sv
// i2c_reg_bank_if: signals between the I2C slave FSM and its register bank
interface i2c_reg_bank_if;
  logic [4:0] slave_state;
  logic [7:0] rx_offset;
  logic [7:0] rx_data;
  logic write_en;
  logic read_en;
  logic [31:0] status_in;
  logic [7:0] tx_data;
  logic [63:0] cfg_out;
  logic wr_strobe;
  logic [3:0] wr_index;
  modport master (output slave_state, rx_offset, rx_data, write_en, read_en, status_in,
                  input tx_data, cfg_out, wr_strobe, wr_index);
  modport slave (input slave_state, rx_offset, rx_data, write_en, read_en, status_in,
                 output tx_data, cfg_out, wr_strobe, wr_index);
endinterface

// File: rtl/i2c_reg_bank_edge_det.sv
// i2c_edge_det: registered level with rise/fall pulses derived against it
module i2c_edge_det (
  input  logic SYSTEM_CLK,
  input  logic RESET,
  input  logic level,
  output logic level_q,
  output logic rise,
  output logic fall
);
  always_ff @(posedge SYSTEM_CLK or posedge RESET)
    if (RESET) level_q <= 1'b0;
    else level_q <= level;
  assign rise = level & ~level_q;
  assign fall = ~level & level_q;
endmodule

// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: I2C slave register bank with auto-incrementing pointer
module i2c_reg_bank
  import i2c_reg_bank_pkg::*;
#(
  parameter logic [7:0]  ID_VALUE  = 8'h5A,
  parameter logic [63:0] CFG_RESET = 64'h0
) (
  input logic SYSTEM_CLK,
  input logic RESET,
  i2c_reg_bank_if.slave bus
);
  logic w_q, w_rise, w_fall, r_q, r_rise, r_fall, m_q, m_rise, m_fall;
  logic pend, unused_edges;
  logic [7:0] ptr;
  logic [63:0] cfg;
  i2c_edge_det u_wr (.SYSTEM_CLK, .RESET, .level(bus.write_en), .level_q(w_q), .rise(w_rise), .fall(w_fall));
  i2c_edge_det u_rd (.SYSTEM_CLK, .RESET, .level(bus.read_en), .level_q(r_q), .rise(r_rise), .fall(r_fall));
  i2c_edge_det u_st (.SYSTEM_CLK, .RESET, .level(bus.slave_state == OFFSET_ACK), .level_q(m_q), .rise(m_rise), .fall(m_fall));
  assign unused_edges = ^{w_q, w_fall, r_q, r_rise, m_q, m_rise};
  assign bus.wr_strobe = pend & (ptr <= RW_LAST);
  assign bus.cfg_out = cfg;
  // pend marks the commit cycle; discards to RO/unmapped still advance ptr
  always_ff @(posedge SYSTEM_CLK or posedge RESET)
    if (RESET) begin
      pend <= 1'b0;
      ptr <= 8'h00;
      cfg <= CFG_RESET;
      bus.tx_data <= CFG_RESET[7:0];
      bus.wr_index <= 4'h0;
    end else begin
      pend <= w_rise;
      if (bus.wr_strobe) begin
        cfg[{ptr[2:0], 3'b000} +: 8] <= bus.rx_data;
        bus.wr_index <= ptr[3:0];
      end
      ptr <= m_fall ? bus.rx_offset : (pend | r_fall) ? ptr + 8'd1 : ptr;
      bus.tx_data <= map_read(ptr, cfg, bus.status_in, ID_VALUE);
    end
endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb_i2c_reg_bank: directed and random transactions checked against a byte-array model
module tb_i2c_reg_bank;
  localparam logic [63:0] CFG_INIT = 64'h8877_6655_4433_2211;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  i2c_reg_bank_if bus ();
  i2c_reg_bank #(.ID_VALUE(8'h5A), .CFG_RESET(CFG_INIT)) dut (.SYSTEM_CLK(clk), .RESET(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  int strobes = 0;
  logic [7:0] cfg_m [8];
  logic [7:0] ptr_m;
  always @(negedge clk) if (bus.wr_strobe === 1'b1) strobes++;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] exp_map(input logic [7:0] o);
    if (o < 8) return cfg_m[o[2:0]];
    if (o < 12) return 8'((bus.status_in >> (8 * (o - 8))) & 32'hFF);
    if (o < 15) return 8'h00;
    if (o == 15) return 8'h5A;
    return 8'hFF;
  endfunction
  function automatic logic [63:0] cfg_img();
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v = v | (64'(cfg_m[i]) << (8 * i));
    return v;
  endfunction
  task automatic reset_model();
    logic [63:0] c = CFG_INIT;
    for (int i = 0; i < 8; i++) cfg_m[i] = 8'((c >> (8 * i)) & 64'hFF);
    ptr_m = 8'h00;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ptr(input logic [7:0] o);
    bus.slave_state = 5'd6;
    bus.rx_offset = o;
    tick();
    bus.slave_state = 5'd7;
    tick();
    ptr_m = o;
    bus.slave_state = 5'd0;
    tick();
    chk("ptr_load", dut.ptr, ptr_m);
  endtask
  task automatic write_byte(input logic [7:0] d);
    bus.rx_data = d;
    bus.write_en = 1'b1;
    tick();
    chk("wr_strobe_on", bus.wr_strobe, ptr_m < 8);
    tick();
    chk("wr_strobe_off", bus.wr_strobe, 1'b0);
    if (ptr_m < 8) begin
      cfg_m[ptr_m[2:0]] = d;
      chk("wr_index", bus.wr_index, ptr_m[3:0]);
    end
    chk("cfg_out", bus.cfg_out, cfg_img());
    ptr_m = ptr_m + 8'd1;
    chk("ptr_wr", dut.ptr, ptr_m);
    bus.write_en = 1'b0;
    tick();
  endtask
  task automatic read_byte();
    tick();
    bus.read_en = 1'b1;
    tick();
    chk("tx_data", bus.tx_data, exp_map(ptr_m));
    bus.read_en = 1'b0;
    tick();
    ptr_m = ptr_m + 8'd1;
    chk("ptr_rd", dut.ptr, ptr_m);
  endtask
  initial begin
    int s0;
    logic [7:0] v;
    int changes;
    bus.slave_state = 5'd0;
    bus.rx_offset = 8'h00;
    bus.rx_data = 8'h00;
    bus.write_en = 1'b0;
    bus.read_en = 1'b0;
    bus.status_in = 32'hC3B2_A190;
    #2 rst = 1'b1;
    #1;
    chk("rst_tx", bus.tx_data, 8'h11);
    chk("rst_cfg", bus.cfg_out, CFG_INIT);
    chk("rst_strobe", bus.wr_strobe, 1'b0);
    chk("rst_index", bus.wr_index, 4'h0);
    chk("rst_ptr", dut.ptr, 8'h00);
    #4 rst = 1'b0;
    reset_model();
    tick();
    s0 = strobes;
    set_ptr(8'h02);
    write_byte(8'h10);
    write_byte(8'h11);
    write_byte(8'h12);
    chk("burst_strobes", strobes - s0, 3);
    chk("burst_ptr", dut.ptr, 8'h05);
    chk("burst_cfg", bus.cfg_out[39:16], 24'h12_1110);
    set_ptr(8'h0E);
    bus.slave_state = 5'd1;
    tick();
    bus.slave_state = 5'd0;
    read_byte();
    read_byte();
    read_byte();
    chk("rs_ptr", dut.ptr, 8'h11);
    s0 = strobes;
    set_ptr(8'h09);
    write_byte(8'hAA);
    chk("ro_strobes", strobes - s0, 0);
    chk("ro_ptr", dut.ptr, 8'h0A);
    tick();
    bus.read_en = 1'b1;
    tick();
    chk("ro_read", bus.tx_data, bus.status_in[23:16]);
    bus.read_en = 1'b0;
    tick();
    ptr_m = ptr_m + 8'd1;
    set_ptr(8'hFF);
    write_byte(8'h33);
    write_byte(8'h44);
    chk("wrap_cfg0", bus.cfg_out[7:0], 8'h44);
    chk("wrap_ptr", dut.ptr, 8'h01);
    s0 = strobes;
    set_ptr(8'h03);
    bus.rx_data = 8'h77;
    bus.write_en = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    reset_model();
    chk("midrst_strobe", bus.wr_strobe, 1'b0);
    chk("midrst_cfg", bus.cfg_out, CFG_INIT);
    chk("midrst_ptr", dut.ptr, 8'h00);
    bus.write_en = 1'b0;
    tick();
    #2 rst = 1'b0;
    tick();
    chk("midrst_nostrobe", strobes - s0, 0);
    write_byte(8'h5C);
    chk("postrst_strobe", strobes - s0, 1);
    set_ptr(8'h09);
    tick();
    bus.read_en = 1'b1;
    tick();
    v = bus.tx_data;
    chk("hold_first", v, exp_map(8'h09));
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.tx_data !== v) changes++;
    end
    chk("hold_changes", changes, 0);
    chk("hold_ptr", dut.ptr, 8'h09);
    bus.read_en = 1'b0;
    tick();
    tick();
    tick();
    ptr_m = ptr_m + 8'd1;
    chk("hold_ptr_after", dut.ptr, 8'h0A);
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: set_ptr(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 17)));
        1: write_byte(8'($urandom));
        2: read_byte();
        default: begin
          bus.status_in = $urandom;
          tick();
          tick();
          chk("status_tx", bus.tx_data, exp_map(ptr_m));
        end
      endcase
    end
    chk("final_cfg", bus.cfg_out, cfg_img());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
